// File: rtl/vga_timing_gen.sv
`default_nettype none
// vga_timing_gen: VGA raster timing generator with pixel clock-enable and a two-stage sync/DE/colour pipeline.
// Revision 1.0
module vga_timing_gen #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 12,
  parameter int   COLOR_W  = 4
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  output logic               O_pix_ce,
  output logic [CNT_W-1:0]   O_x,
  output logic [CNT_W-1:0]   O_y,
  output logic               O_active,
  output logic               O_line_start,
  output logic               O_frame_start,
  input  logic [COLOR_W-1:0] I_red,
  input  logic [COLOR_W-1:0] I_green,
  input  logic [COLOR_W-1:0] I_blue,
  output logic               O_hs,
  output logic               O_vs,
  output logic               O_de,
  output logic [COLOR_W-1:0] O_red,
  output logic [COLOR_W-1:0] O_green,
  output logic [COLOR_W-1:0] O_blue
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_BEG   = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_BEG   = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYN_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_C = CNT_W'(V_SYNC);

  logic             ce;
  logic [CNT_W-1:0] h;
  logic [CNT_W-1:0] v;
  logic             h_wrap;
  logic             v_wrap;
  logic             in_active;
  logic             hs1;
  logic             vs1;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int DIV_W = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      logic [DIV_W-1:0] div;

      always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
          div <= '0;
        end else if (div == DIV_LAST) begin
          div <= '0;
        end else begin
          div <= div + DIV_W'(1);
        end
      end

      assign ce = (div == DIV_LAST);
    end else begin : g_nodiv
      // Every clock is a pixel; held low only while reset is asserted.
      assign ce = I_rst_n;
    end
  endgenerate

  assign O_pix_ce = ce;

  assign h_wrap    = (h == H_LAST);
  assign v_wrap    = (v == V_LAST);
  assign in_active = (h >= H_BEG) && (h < H_END) && (v >= V_BEG) && (v < V_END);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      h <= h_wrap ? '0 : h + CNT_W'(1);
      if (h_wrap) begin
        v <= v_wrap ? '0 : v + CNT_W'(1);
      end
    end
  end

  // Stage 1: coordinates and markers from the pre-advance counter values.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_x           <= '0;
      O_y           <= '0;
      O_active      <= 1'b0;
      hs1           <= 1'b0;
      vs1           <= 1'b0;
      O_line_start  <= 1'b0;
      O_frame_start <= 1'b0;
    end else begin
      O_line_start  <= ce && (h == '0);
      O_frame_start <= ce && (h == '0) && (v == '0);
      if (ce) begin
        O_active <= in_active;
        O_x      <= in_active ? h - H_BEG : '0;
        O_y      <= in_active ? v - V_BEG : '0;
        hs1      <= (h < H_SYN_C);
        vs1      <= (v < V_SYN_C);
      end
    end
  end

  // Stage 2: syncs, DE and colour leave together, one pixel behind stage 1.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_hs    <= ~HS_POL;
      O_vs    <= ~VS_POL;
      O_de    <= 1'b0;
      O_red   <= '0;
      O_green <= '0;
      O_blue  <= '0;
    end else if (ce) begin
      O_hs    <= hs1 ? HS_POL : ~HS_POL;
      O_vs    <= vs1 ? VS_POL : ~VS_POL;
      O_de    <= O_active;
      O_red   <= O_active ? I_red   : '0;
      O_green <= O_active ? I_green : '0;
      O_blue  <= O_active ? I_blue  : '0;
    end
  end

endmodule
`default_nettype wire
